// File: rtl/bomb_pkg.sv
// Shared types and constants for the bomb round controller: state encoding,
// LFSR parameters and the cut-order derivation used when a round is armed.
package bomb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_DEFUSED,
    ST_EXPLODED
  } state_e;

  localparam logic [7:0] LFSR_TAPS         = 8'hB8;
  localparam logic [7:0] LFSR_SEED_DEFAULT = 8'hA5;
  localparam int         NUM_WIRES         = 8;
  localparam int         IDX_W             = 3;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

  // Each later index is offset by at least one from the previous, so the three never collide.
  function automatic logic [3*IDX_W-1:0] make_seq(input logic [7:0] v);
    logic [IDX_W-1:0] s0, s1, s2;
    s0 = v[2:0];
    s1 = s0 + 3'd1 + {1'b0, v[4:3]};
    s2 = s1 + 3'd1 + {2'b0, v[5]};
    return {s2, s1, s0};
  endfunction

endpackage

// File: rtl/bomb_round_ctrl_sync_edge.sv
// Two-flop synchronizer with a per-bit rising-edge detector on the synchronized value.
module sync_edge #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] meta_q, sync_q, prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/bomb_round_ctrl.sv
// Round controller: arms a countdown, latches a secret 3-wire cut order from a free-running
// LFSR and reports defuse/explode, handing off to the win animation via success/repeat_rst.
module bomb_round_ctrl
  import bomb_pkg::*;
#(
  parameter int         TICK_DIV   = 50_000_000,
  parameter int         ROUND_SECS = 30,
  parameter logic [7:0] LFSR_SEED  = LFSR_SEED_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [NUM_WIRES-1:0]   wire_cut,
  input  logic                   repeat_rst,
  output logic                   ready,
  output logic                   armed,
  output logic                   success,
  output logic                   fail,
  output logic [5:0]             secs_left,
  output logic [1:0]             step,
  output logic                   tick,
  output logic [3*IDX_W-1:0]     seq_o
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [5:0]    SECS_INIT = 6'(ROUND_SECS);

  logic [NUM_WIRES-1:0] wire_sync, new_cut;
  logic                 start_sync, start_rise, rep_sync, rep_rise;
  logic                 unused_sync;

  sync_edge #(.WIDTH(NUM_WIRES)) u_sync_wire (
    .clk(clk), .rst_n(rst_n), .async_i(wire_cut), .sync_o(wire_sync), .rise_o(new_cut)
  );
  sync_edge #(.WIDTH(1)) u_sync_start (
    .clk(clk), .rst_n(rst_n), .async_i(start), .sync_o(start_sync), .rise_o(start_rise)
  );
  sync_edge #(.WIDTH(1)) u_sync_rep (
    .clk(clk), .rst_n(rst_n), .async_i(repeat_rst), .sync_o(rep_sync), .rise_o(rep_rise)
  );

  assign unused_sync = start_sync ^ rep_rise;

  state_e               state_q, state_d;
  logic [7:0]           lfsr_q;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [5:0]           secs_q, secs_d;
  logic [1:0]           step_q, step_d;
  logic [3*IDX_W-1:0]   seq_q, seq_d;
  logic                 tick_q, tick_d;
  logic                 ready_q, armed_q, success_q, fail_q;
  logic                 wrap;
  logic [IDX_W-1:0]     exp_idx;

  always_comb begin
    exp_idx = seq_q[IDX_W-1:0];
    case (step_q)
      2'd1:    exp_idx = seq_q[2*IDX_W-1:IDX_W];
      2'd2:    exp_idx = seq_q[3*IDX_W-1:2*IDX_W];
      default: exp_idx = seq_q[IDX_W-1:0];
    endcase
  end

  assign wrap = (state_q == ST_ARMED) && (tick_cnt_q == TICK_LAST);

  always_comb begin
    state_d    = state_q;
    secs_d     = secs_q;
    step_d     = step_q;
    seq_d      = seq_q;
    tick_cnt_d = '0;
    tick_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_rise && ready_q) begin
          state_d = ST_ARMED;
          secs_d  = SECS_INIT;
          step_d  = 2'd0;
          seq_d   = make_seq(lfsr_q);
        end
      end
      ST_ARMED: begin
        tick_cnt_d = wrap ? '0 : tick_cnt_q + TW'(1);
        tick_d     = wrap;
        // Timeout outranks any cut landing on the same edge.
        if (wrap && (secs_q == 6'd1)) begin
          state_d = ST_EXPLODED;
          secs_d  = 6'd0;
        end else begin
          if (wrap) secs_d = secs_q - 6'd1;
          if (|new_cut) begin
            if (new_cut == (NUM_WIRES'(1) << exp_idx)) begin
              step_d = step_q + 2'd1;
              if (step_q == 2'd2) state_d = ST_DEFUSED;
            end else begin
              state_d = ST_EXPLODED;
            end
          end
        end
      end
      ST_DEFUSED: begin
        if (rep_sync) begin
          state_d = ST_IDLE;
          secs_d  = SECS_INIT;
          step_d  = 2'd0;
        end
      end
      ST_EXPLODED: begin
        if (rep_sync || start_rise) begin
          state_d = ST_IDLE;
          secs_d  = SECS_INIT;
          step_d  = 2'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      lfsr_q     <= LFSR_SEED;
      tick_cnt_q <= '0;
      secs_q     <= SECS_INIT;
      step_q     <= 2'd0;
      seq_q      <= '0;
      tick_q     <= 1'b0;
      ready_q    <= 1'b0;
      armed_q    <= 1'b0;
      success_q  <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_next(lfsr_q);
      tick_cnt_q <= tick_cnt_d;
      secs_q     <= secs_d;
      step_q     <= step_d;
      seq_q      <= seq_d;
      tick_q     <= tick_d;
      ready_q    <= (state_d == ST_IDLE) && (wire_sync == '0);
      armed_q    <= (state_d == ST_ARMED);
      success_q  <= (state_d == ST_DEFUSED);
      fail_q     <= (state_d == ST_EXPLODED);
    end
  end

  assign ready     = ready_q;
  assign armed     = armed_q;
  assign success   = success_q;
  assign fail      = fail_q;
  assign secs_left = secs_q;
  assign step      = step_q;
  assign tick      = tick_q;
  assign seq_o     = seq_q;

endmodule

// File: tb/tb_bomb_round_ctrl.sv
// Self-checking bench for bomb_round_ctrl: directed and randomized rounds checked against a
// cycle-offset model of the countdown, cut order and outcome.
module tb_bomb_round_ctrl;

  localparam int         TICK_DIV     = 10;
  localparam int         ROUND_SECS   = 3;
  localparam logic [7:0] SEED         = 8'hA5;
  localparam int         TIMEOUT_EDGE = TICK_DIV * ROUND_SECS;
  localparam int         LAST_CYC     = TIMEOUT_EDGE + 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       repeat_rst = 1'b0;
  logic [7:0] wire_cut = 8'h00;
  logic       ready, armed, success, fail, tick;
  logic [5:0] secs_left;
  logic [1:0] step;
  logic [8:0] seq_o;

  int compared = 0;
  int mismatched = 0;
  int edgeCount;
  int expSeq [3];

  bomb_round_ctrl #(
    .TICK_DIV(TICK_DIV), .ROUND_SECS(ROUND_SECS), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .wire_cut(wire_cut), .repeat_rst(repeat_rst),
    .ready(ready), .armed(armed), .success(success), .fail(fail),
    .secs_left(secs_left), .step(step), .tick(tick), .seq_o(seq_o)
  );

  always #5 clk = ~clk;

  // Clock edges seen since reset release; tells the model how far the LFSR has advanced.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edgeCount <= 0;
    else        edgeCount <= edgeCount + 1;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] lfsrAfter(input int n);
    logic [7:0] v;
    v = SEED;
    for (int i = 0; i < n; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    return v;
  endfunction

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic s, input logic [7:0] w, input logic r);
    start      = s;
    wire_cut   = w;
    repeat_rst = r;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raise start; the round is armed on the third edge, using the LFSR value just before it.
  task automatic armRound(input string tag);
    logic [7:0] l;
    l = lfsrAfter(edgeCount + 2);
    expSeq[0] = int'(l[2:0]);
    expSeq[1] = (expSeq[0] + 1 + int'(l[4:3])) % 8;
    expSeq[2] = (expSeq[1] + 1 + int'(l[5])) % 8;
    applyStimulus(1'b1, 8'h00, 1'b0);
    waitCycles(3);
    checkOutput({tag, " armed"}, armed, 1);
    checkOutput({tag, " seq"}, seq_o, (expSeq[2] << 6) | (expSeq[1] << 3) | expSeq[0]);
    checkOutput({tag, " secs"}, secs_left, ROUND_SECS);
    applyStimulus(1'b0, 8'h00, 1'b0);
  endtask

  task automatic recoverRound(input string tag);
    applyStimulus(1'b0, 8'h00, 1'b0);
    waitCycles(3);
    applyStimulus(1'b0, 8'h00, 1'b1);
    waitCycles(3);
    checkOutput({tag, " rec success"}, success, 0);
    checkOutput({tag, " rec fail"}, fail, 0);
    checkOutput({tag, " rec ready"}, ready, 1);
    checkOutput({tag, " rec secs"}, secs_left, ROUND_SECS);
    checkOutput({tag, " rec step"}, step, 0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    waitCycles(3);
  endtask

  // Cuts seq[i] at cycle offset t[i] after arming and checks every cycle against
  // the outcome implied by when each cut takes effect relative to the timeout.
  task automatic runRound(input string tag, input int t0, input int t1, input int t2);
    int t [3];
    int e [3];
    int endEdge, expStep, expSecs, upTo;
    bit won;
    t[0] = t0; t[1] = t1; t[2] = t2;
    for (int i = 0; i < 3; i++) e[i] = t[i] + 3;
    won     = (e[2] < TIMEOUT_EDGE);
    endEdge = won ? e[2] : TIMEOUT_EDGE;
    for (int cyc = 0; cyc <= LAST_CYC; cyc++) begin
      expStep = 0;
      for (int i = 0; i < 3; i++) if (e[i] <= cyc && e[i] < TIMEOUT_EDGE) expStep++;
      upTo    = (cyc < endEdge) ? cyc : endEdge;
      expSecs = ROUND_SECS - upTo / TICK_DIV;
      checkOutput($sformatf("%s c%0d step", tag, cyc), step, expStep);
      checkOutput($sformatf("%s c%0d secs", tag, cyc), secs_left, expSecs);
      checkOutput($sformatf("%s c%0d tick", tag, cyc), tick,
                  (cyc > 0 && cyc % TICK_DIV == 0 && cyc <= endEdge) ? 1 : 0);
      checkOutput($sformatf("%s c%0d armed", tag, cyc), armed, (cyc < endEdge) ? 1 : 0);
      checkOutput($sformatf("%s c%0d success", tag, cyc), success, (won && cyc >= endEdge) ? 1 : 0);
      checkOutput($sformatf("%s c%0d fail", tag, cyc), fail, (!won && cyc >= endEdge) ? 1 : 0);
      checkOutput($sformatf("%s c%0d ready", tag, cyc), ready, 0);
      for (int i = 0; i < 3; i++)
        if (cyc == t[i]) wire_cut = wire_cut | 8'(1 << expSeq[i]);
      waitCycles(1);
    end
  endtask

  initial begin
    int w, a, b, c;

    // Reset state
    waitCycles(2);
    checkOutput("rst ready", ready, 0);
    checkOutput("rst armed", armed, 0);
    checkOutput("rst success", success, 0);
    checkOutput("rst fail", fail, 0);
    checkOutput("rst secs", secs_left, ROUND_SECS);
    checkOutput("rst step", step, 0);
    checkOutput("rst tick", tick, 0);
    checkOutput("rst seq", seq_o, 0);
    rst_n = 1'b1;
    waitCycles(3);
    checkOutput("idle ready", ready, 1);

    // Correct defuse at 5-cycle spacing, then the repeat handshake
    armRound("defuse");
    runRound("defuse", 0, 5, 10);
    applyStimulus(1'b0, 8'h00, 1'b0);
    waitCycles(3);
    applyStimulus(1'b0, 8'h00, 1'b1);
    waitCycles(2);
    checkOutput("hs success held", success, 1);
    waitCycles(1);
    checkOutput("hs success", success, 0);
    checkOutput("hs secs", secs_left, ROUND_SECS);
    checkOutput("hs step", step, 0);
    checkOutput("hs ready", ready, 1);
    checkOutput("hs seq held", seq_o, (expSeq[2] << 6) | (expSeq[1] << 3) | expSeq[0]);
    applyStimulus(1'b0, 8'h00, 1'b0);
    waitCycles(3);

    // Wrong wire, then start_rise returns to idle
    armRound("wrong");
    w = (expSeq[0] + int'($urandom_range(1, 7))) % 8;
    applyStimulus(1'b0, 8'(1 << w), 1'b0);
    waitCycles(3);
    checkOutput("wrong fail", fail, 1);
    checkOutput("wrong step", step, 0);
    checkOutput("wrong armed", armed, 0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    waitCycles(3);
    applyStimulus(1'b1, 8'h00, 1'b0);
    waitCycles(3);
    checkOutput("wrong restart fail", fail, 0);
    checkOutput("wrong restart armed", armed, 0);
    checkOutput("wrong restart ready", ready, 1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    waitCycles(3);

    // Timeout with no cuts
    armRound("timeout");
    runRound("timeout", 1000, 1001, 1002);
    recoverRound("timeout");

    // Two wires including seq0 in the same cycle
    armRound("double");
    w = (expSeq[0] + int'($urandom_range(1, 7))) % 8;
    applyStimulus(1'b0, 8'(1 << expSeq[0]) | 8'(1 << w), 1'b0);
    waitCycles(3);
    checkOutput("double fail", fail, 1);
    checkOutput("double step", step, 0);
    recoverRound("double");

    // Final correct cut on the timeout edge, and one edge earlier
    armRound("late");
    runRound("late", 0, 5, TIMEOUT_EDGE - 3);
    recoverRound("late");
    armRound("justin");
    runRound("justin", 0, 5, TIMEOUT_EDGE - 4);
    recoverRound("justin");

    // Randomized cut timing
    for (int r = 0; r < 4; r++) begin
      a = int'($urandom_range(0, 4));
      b = a + int'($urandom_range(1, 8));
      c = b + int'($urandom_range(1, 20));
      armRound($sformatf("rnd%0d", r));
      runRound($sformatf("rnd%0d", r), a, b, c);
      recoverRound($sformatf("rnd%0d", r));
    end

    // Start while a wire is cut in idle is ignored
    applyStimulus(1'b0, 8'h01, 1'b0);
    waitCycles(3);
    checkOutput("guard ready", ready, 0);
    applyStimulus(1'b1, 8'h01, 1'b0);
    waitCycles(5);
    checkOutput("guard armed", armed, 0);
    checkOutput("guard ready held", ready, 0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    waitCycles(4);
    checkOutput("guard ready back", ready, 1);
    checkOutput("guard still idle", armed, 0);

    // Asynchronous reset mid-round, then the LFSR restarts from the seed
    armRound("midrst");
    waitCycles(5);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst ready", ready, 0);
    checkOutput("midrst armed", armed, 0);
    checkOutput("midrst success", success, 0);
    checkOutput("midrst fail", fail, 0);
    checkOutput("midrst secs", secs_left, ROUND_SECS);
    checkOutput("midrst step", step, 0);
    checkOutput("midrst tick", tick, 0);
    checkOutput("midrst seq", seq_o, 0);
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(3);
    armRound("postrst");
    runRound("postrst", 1, 3, 6);
    recoverRound("postrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bomb_round_ctrl.md
# bomb_round_ctrl

Round controller for the bomb dismantlement game. It arms a countdown, generates a secret 3-wire cut order, and watches the eight wire switches. It raises `success` when the wires are cut in the correct order before time runs out, and `fail` on a wrong cut or timeout. It is the producing end of the `success`/`repeatRst` handshake with the win-animation block: it drives `success` to that block and returns to idle when that block answers with its repeat-reset level.

## Interface
- `TICK_DIV`, default 50_000_000: clk cycles per one-second tick; legal range ≥2.
- `ROUND_SECS`, default 30: countdown start value; legal range 1..63.
- `LFSR_SEED`, default 8'hA5: LFSR value after reset; must be nonzero.

Ports (reset rst_n, asynchronous, active-low; clock clk):
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: level, asynchronous switch/button; arms a round.
- `wire_cut` in 8: asynchronous switches; 1 = wire cut.
- `repeat_rst` in 1: level from the win-animation block; ends a won round.
- `ready` out 1: IDLE and all synchronized wires intact.
- `armed` out 1: in ARMED.
- `success` out 1: in DEFUSED.
- `fail` out 1: in EXPLODED.
- `secs_left` out 6: remaining seconds.
- `step` out 2: correct cuts so far, 0..3.
- `tick` out 1: one-cycle pulse per second while ARMED.
- `seq_o` out 9: {seq2, seq1, seq0}, the latched cut order, for the bench and debug.

## Operation
- **Input synchronization**
  - `start`, `wire_cut` and `repeat_rst` each pass through a 2-flop synchronizer.
  - `new_cut` = synchronized `wire_cut` & ~previous synchronized `wire_cut`, a per-bit rising edge.
  - `start_rise` is the rising edge of synchronized `start`.
- **LFSR**
  - 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, shifting left every clk in all states.
  - Reset value is `LFSR_SEED`.
- **Sequence latch on arming**, all arithmetic mod 8:
  - seq0 = lfsr[2:0]
  - seq1 = seq0 + 1 + lfsr[4:3]
  - seq2 = seq1 + 1 + lfsr[5]
  - These rules guarantee three distinct indices.
- **States** (one-hot or binary encoding is free):
  - IDLE: → ARMED on `start_rise` && `ready`. On that transition, load secs_left=ROUND_SECS, step=0, tick counter=0, and latch the sequence. `start_rise` while not `ready` is ignored.
  - ARMED, on a tick when secs_left==1: → EXPLODED, with secs_left→0.
  - ARMED, otherwise when any `new_cut` is present:
    - If exactly one bit is set and its index == seq[step]: step+1. When step reaches 3, → DEFUSED.
    - Any other nonzero `new_cut` (a wrong wire, or two or more bits in one cycle): → EXPLODED.
  - ARMED: un-cutting a wire (falling edge) is ignored.
  - DEFUSED: hold `secs_left` and `step`. → IDLE when synchronized `repeat_rst`=1.
  - EXPLODED: → IDLE on synchronized `repeat_rst`=1 or on `start_rise`.
  - Entering IDLE: secs_left=ROUND_SECS and step=0; `seq_o` holds its last value.
- **Simultaneous events**
  - Timeout outranks a cut in the same cycle, including a correct final cut.
  - `start_rise` in ARMED or DEFUSED is ignored.
- **Tick counter**
  - Counts 0..TICK_DIV-1 only in ARMED and wraps to 0.
  - `tick` is asserted on the wrap cycle; secs_left decrements on the same edge.

## Timing
- Reset values: `ready`=0 until the synchronizers settle, `armed`=0, `success`=0, `fail`=0, secs_left=ROUND_SECS, step=0, tick=0, seq_o=0. The state is IDLE.
- Input-to-state latency: 3 clk from an asynchronous edge (2 synchronizer flops plus 1 edge/state register). All outputs are registered.
- The first `tick` comes TICK_DIV cycles after entering ARMED.
- Timeout occurs ROUND_SECS×TICK_DIV cycles after entering ARMED, absent a cut.
- `success` stays high until `repeat_rst` is seen. Then 1 cycle later the state is IDLE and `success`=0.
- Reset asserted mid-round forces IDLE immediately (asynchronous). The LFSR returns to the seed.

## Structure
- Package `bomb_pkg` holds:
  - the state enum (IDLE, ARMED, DEFUSED, EXPLODED);
  - LFSR tap mask 8'hB8 and default seed;
  - wire count 8 and index width 3.
- Sub-module `sync_edge` (parameterized width): 2-flop synchronizer plus rising-edge detect, instantiated for `wire_cut`, `start` and `repeat_rst`.

## Test plan
Every scenario runs with TICK_DIV=10 and ROUND_SECS=3.
- **Correct defuse:** pulse start, read seq_o, cut seq0, seq1, seq2 at 5-cycle spacing → step goes 1, 2, 3; `success`=1 and `armed`=0; secs_left frozen.
- **Handshake return:** from DEFUSED, raise repeat_rst → IDLE 3 cycles later: success=0, secs_left=3, step=0, ready=1.
- **Wrong wire:** arm, cut a wire whose index is not seq0 → fail=1, step=0; later start_rise → IDLE.
- **Timeout:** arm with no cuts → tick pulses at 10, 20, 30 cycles after arming; secs_left goes 2, 1, 0; fail=1 at the third tick.
- **Double cut and precedence:**
  - Cutting seq0 and another wire in the same cycle → EXPLODED.
  - Correct third cut landing on the timeout tick → EXPLODED, not DEFUSED.
- **Guards:**
  - start while wire_cut=8'h01 → stays IDLE with ready=0.
  - rst_n low mid-round → all outputs return to their reset values asynchronously.
